// File: rtl/req_arbiter_4_pkg.sv
// Shared types and constants for the four-way request arbiter.
package req_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RECOVER = 2'b10
  } arbState_e;

  // Expand a requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] idToOnehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/req_arbiter_4_sel.sv
// Combinational requester selector: fixed priority (highest index wins)
// or round-robin search starting at a given index and wrapping 3 -> 0.
module pri_sel4
  import req_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  input  logic             rr,
  output logic [N_REQ-1:0] sel_onehot,
  output logic [ID_W-1:0]  sel_id,
  output logic             sel_valid
);

  logic [ID_W-1:0] idx;

  // Pick the winning requester; in fixed mode later (higher) indices overwrite earlier ones.
  always_comb begin
    idx       = '0;
    sel_id    = '0;
    sel_valid = 1'b0;
    if (rr) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = start + ID_W'(k);
        if (!sel_valid && req[idx]) begin
          sel_id    = idx;
          sel_valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          sel_id    = ID_W'(i);
          sel_valid = 1'b1;
        end
      end
    end
    sel_onehot = sel_valid ? idToOnehot(sel_id) : '0;
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with fixed/round-robin selection, a bounded hold
// time that force-releases a grant, and a dead RECOVER cycle between grants.
module req_arbiter_4
  import req_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] MaxHoldC = HOLD_W'(MAX_HOLD);

  arbState_e         state_q;
  logic [HOLD_W-1:0] holdCnt_q;
  logic [ID_W-1:0]   lastId_q;
  logic              ready_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   gntId_q;
  logic              busy_q;
  logic              timeout_q;

  logic [ID_W-1:0]   startId;
  logic [N_REQ-1:0]  selOnehot;
  logic [ID_W-1:0]   selId;
  logic              selValid;

  assign startId = lastId_q + ID_W'(1);

  pri_sel4 uSel (
    .req        (req),
    .start      (startId),
    .rr         (mode),
    .sel_onehot (selOnehot),
    .sel_id     (selId),
    .sel_valid  (selValid)
  );

  // Arbiter FSM with registered grant outputs; ready_q holds off any grant
  // on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      lastId_q  <= 2'b11;
      ready_q   <= 1'b0;
      gnt_q     <= '0;
      gntId_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_q && selValid) begin
            state_q   <= GRANT;
            gnt_q     <= selOnehot;
            gntId_q   <= selId;
            lastId_q  <= selId;
            busy_q    <= 1'b1;
            holdCnt_q <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (!req[gntId_q]) begin
            state_q   <= RECOVER;
            gnt_q     <= '0;
            gntId_q   <= '0;
            busy_q    <= 1'b0;
            holdCnt_q <= '0;
          end else if (holdCnt_q == MaxHoldC) begin
            state_q   <= RECOVER;
            gnt_q     <= '0;
            gntId_q   <= '0;
            busy_q    <= 1'b0;
            holdCnt_q <= '0;
            timeout_q <= 1'b1;
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end
        RECOVER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          gntId_q   <= '0;
          busy_q    <= 1'b0;
          holdCnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gntId_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed testbench for req_arbiter_4 built with MAX_HOLD = 4.
module tb_req_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int tests;
  int fails;

  req_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mode    (mode),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset and leave the arbiter idle and ready to grant.
  task automatic doReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // Reset values, and no grant on the first edge after release.
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    mode  = 1'b1;
    @(negedge clk);
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    tests++; if (gnt_id !== 2'b00) begin fails++; $display("[TB] FAIL reset_gnt_id: got %b expected %b", gnt_id, 2'b00); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b expected %b", timeout, 1'b0); end
    rst_n = 1'b1;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL first_edge_no_grant: got %b expected %b", gnt, 4'b0000); end
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL first_rr_grant: got %b expected %b", gnt, 4'b0001); end
    tests++; if (gnt_id !== 2'b00) begin fails++; $display("[TB] FAIL first_rr_gnt_id: got %b expected %b", gnt_id, 2'b00); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Fixed priority, mode ignored mid-grant, RECOVER ignores requests.
  task automatic test_fixed();
    doReset();
    mode = 1'b0;
    req  = 4'b0110;
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL fixed_gnt: got %b expected %b", gnt, 4'b0100); end
    tests++; if (gnt_id !== 2'b10) begin fails++; $display("[TB] FAIL fixed_gnt_id: got %b expected %b", gnt_id, 2'b10); end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL fixed_busy: got %b expected %b", busy, 1'b1); end
    mode = 1'b1;
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL fixed_mode_change_hold: got %b expected %b", gnt, 4'b0100); end
    req = 4'b0000;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL fixed_release_gnt: got %b expected %b", gnt, 4'b0000); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL fixed_release_busy: got %b expected %b", busy, 1'b0); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL fixed_release_timeout: got %b expected %b", timeout, 1'b0); end
    mode = 1'b0;
    req  = 4'b1011;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL recover_ignores_req: got %b expected %b", gnt, 4'b0000); end
    tick();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("[TB] FAIL fixed_highest_gnt: got %b expected %b", gnt, 4'b1000); end
    tests++; if (gnt_id !== 2'b11) begin fails++; $display("[TB] FAIL fixed_highest_id: got %b expected %b", gnt_id, 2'b11); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Round-robin order 0,1,2,3,0 with all requesters active.
  task automatic test_round_robin();
    logic [3:0] expGnt;
    logic [1:0] expId;
    doReset();
    mode = 1'b1;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expId  = 2'(k % 4);
      expGnt = 4'b0001 << expId;
      tick();
      tests++; if (gnt !== expGnt) begin fails++; $display("[TB] FAIL rr_gnt_%0d: got %b expected %b", k, gnt, expGnt); end
      tests++; if (gnt_id !== expId) begin fails++; $display("[TB] FAIL rr_id_%0d: got %b expected %b", k, gnt_id, expId); end
      req = 4'b1111 & ~expGnt;
      tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL rr_gap_%0d: got %b expected %b", k, gnt, 4'b0000); end
      req = 4'b1111;
      tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL rr_idle_%0d: got %b expected %b", k, gnt, 4'b0000); end
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  // Forced release after MAX_HOLD cycles, and release coinciding with the limit.
  task automatic test_timeout();
    doReset();
    mode = 1'b0;
    req  = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL hold_gnt_%0d: got %b expected %b", c, gnt, 4'b0001); end
      tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL hold_timeout_%0d: got %b expected %b", c, timeout, 1'b0); end
    end
    tick();
    tests++; if (timeout !== 1'b1) begin fails++; $display("[TB] FAIL timeout_pulse: got %b expected %b", timeout, 1'b1); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL timeout_gnt: got %b expected %b", gnt, 4'b0000); end
    tick();
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL timeout_one_cycle: got %b expected %b", timeout, 1'b0); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL timeout_gap2: got %b expected %b", gnt, 4'b0000); end
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL timeout_regrant: got %b expected %b", gnt, 4'b0001); end
    tick();
    tick();
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL at_limit_gnt: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL simultaneous_release_timeout: got %b expected %b", timeout, 1'b0); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL simultaneous_release_gnt: got %b expected %b", gnt, 4'b0000); end
    tick();
    tick();
  endtask

  // Round-robin wrap-around with timeouts between requesters 0 and 3.
  task automatic test_rr_wrap();
    doReset();
    mode = 1'b1;
    req  = 4'b1001;
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL wrap_first: got %b expected %b", gnt, 4'b0001); end
    tick(); tick(); tick(); tick();
    tests++; if (timeout !== 1'b1) begin fails++; $display("[TB] FAIL wrap_timeout0: got %b expected %b", timeout, 1'b1); end
    tick();
    tick();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("[TB] FAIL wrap_second: got %b expected %b", gnt, 4'b1000); end
    tests++; if (gnt_id !== 2'b11) begin fails++; $display("[TB] FAIL wrap_second_id: got %b expected %b", gnt_id, 2'b11); end
    tick(); tick(); tick(); tick();
    tests++; if (timeout !== 1'b1) begin fails++; $display("[TB] FAIL wrap_timeout3: got %b expected %b", timeout, 1'b1); end
    tick();
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL wrap_third: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Asynchronous reset during a grant drops it with no timeout pulse.
  task automatic test_reset_mid_grant();
    doReset();
    mode = 1'b1;
    req  = 4'b0100;
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL midrst_pre_gnt: got %b expected %b", gnt, 4'b0100); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL midrst_async_gnt: got %b expected %b", gnt, 4'b0000); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_async_busy: got %b expected %b", busy, 1'b0); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL midrst_async_timeout: got %b expected %b", timeout, 1'b0); end
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    tests++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL midrst_post_timeout: got %b expected %b", timeout, 1'b0); end
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL midrst_next_rr: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Other requesters arriving during a grant do not disturb it.
  task automatic test_no_glitch();
    doReset();
    mode = 1'b0;
    req  = 4'b0010;
    tick();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("[TB] FAIL hold1_gnt: got %b expected %b", gnt, 4'b0010); end
    req = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      #4;
      tests++; if (gnt !== 4'b0010) begin fails++; $display("[TB] FAIL hold1_mid_%0d: got %b expected %b", c, gnt, 4'b0010); end
      tick();
      tests++; if (gnt !== 4'b0010) begin fails++; $display("[TB] FAIL hold1_edge_%0d: got %b expected %b", c, gnt, 4'b0010); end
      tests++; if (gnt_id !== 2'b01) begin fails++; $display("[TB] FAIL hold1_id_%0d: got %b expected %b", c, gnt_id, 2'b01); end
    end
    req = 4'b1000;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL hold1_release: got %b expected %b", gnt, 4'b0000); end
    tick();
    tick();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("[TB] FAIL hold1_next: got %b expected %b", gnt, 4'b1000); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Run every scenario in order and report.
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_rr_wrap();
    test_reset_mid_grant();
    test_no_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
